// File: rtl/pipe_deliver_chain.sv
// Chain of DEPTH stall/flush/bubble stage registers (optional PDC_BUBBLE_CNT_EN squash counters).
// Latency: 1 cycle per register, DEPTH cycles end to end when nothing stalls.
// Backpressure: stall[i] freezes the feed into register i; a bubble is inserted only when the downstream side is free.
module pipe_deliver_chain #(
    parameter int                 WIDTH      = 32,
    parameter int                 DEPTH      = 1,
    parameter logic [WIDTH-1:0]   BUBBLE_VAL = '0,
    parameter int                 CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    input  logic [DEPTH:0]           stall,
    input  logic [DEPTH-1:0]         flush,
`ifdef PDC_BUBBLE_CNT_EN
    output logic [CNT_W*DEPTH-1:0]   bubble_cnt,
`endif
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [DEPTH-1:0]         stage_valid,
    output logic [WIDTH*DEPTH-1:0]   stage_data
);

    logic [WIDTH*DEPTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [WIDTH*DEPTH-1:0] up_dat;
    logic [DEPTH-1:0]       up_vld;

    // Upstream slot i holds what register i would load: in_* for 0, register i-1 otherwise.
    for (genvar i = 0; i < DEPTH; i++) begin : g_up
        if (i == 0) begin : g_head
            assign up_dat[0 +: WIDTH] = in_data;
            assign up_vld[0]          = in_valid;
        end else begin : g_link
            assign up_dat[i*WIDTH +: WIDTH] = data_q[(i-1)*WIDTH +: WIDTH];
            assign up_vld[i]                = valid_q[i-1];
        end
    end

`ifdef PDC_BUBBLE_CNT_EN
    logic [CNT_W*DEPTH-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
`ifdef PDC_BUBBLE_CNT_EN
        cnt_d   = cnt_q;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (flush[i] || (stall[i] && !stall[i+1])) begin
                data_d[i*WIDTH +: WIDTH] = BUBBLE_VAL;
                valid_d[i]               = 1'b0;
`ifdef PDC_BUBBLE_CNT_EN
                // Only a squashed valid entry counts; saturate rather than wrap.
                if (valid_q[i] && (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
`endif
            end else if (!stall[i]) begin
                data_d[i*WIDTH +: WIDTH] = up_dat[i*WIDTH +: WIDTH];
                valid_d[i]               = up_vld[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= {DEPTH{BUBBLE_VAL}};
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef PDC_BUBBLE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt = cnt_q;
`endif

    assign out_data    = data_q[(DEPTH-1)*WIDTH +: WIDTH];
    assign out_valid   = valid_q[DEPTH-1];
    assign stage_valid = valid_q;
    assign stage_data  = data_q;

endmodule

// File: tb/tb_pipe_deliver_chain.sv
// Bench for pipe_deliver_chain: WIDTH=32, DEPTH=3, BUBBLE_VAL=0, CNT_W=2; vector table plus reset sequences.
module tb_pipe_deliver_chain;

    localparam int W  = 32;
    localparam int D  = 3;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    in_data;
    logic            in_valid;
    logic [D:0]      stall;
    logic [D-1:0]    flush;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic [D-1:0]    stage_valid;
    logic [W*D-1:0]  stage_data;
`ifdef PDC_BUBBLE_CNT_EN
    logic [CW*D-1:0] bubble_cnt;
`endif

    pipe_deliver_chain #(
        .WIDTH(W), .DEPTH(D), .BUBBLE_VAL('0), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .stall(stall), .flush(flush),
`ifdef PDC_BUBBLE_CNT_EN
        .bubble_cnt(bubble_cnt),
`endif
        .out_data(out_data), .out_valid(out_valid),
        .stage_valid(stage_valid), .stage_data(stage_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] in_dat;
        logic        in_vld;
        logic [3:0]  stl;
        logic [2:0]  fls;
        logic [95:0] exp_dat;   // {reg2, reg1, reg0}
        logic [2:0]  exp_vld;
        logic [5:0]  exp_cnt;   // {cnt2, cnt1, cnt0}
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];
    vec_t exp_q [$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_cnt(input string nm, input logic [5:0] exp);
`ifdef PDC_BUBBLE_CNT_EN
        check(nm, 96'(bubble_cnt), 96'(exp));
`else
        if (exp === 6'bx) $display("unreachable %s", nm);
`endif
    endtask

    initial begin
        vecs[0]  = '{32'h11, 1'b1, 4'b0000, 3'b000, {32'h00, 32'h00, 32'h11}, 3'b001, 6'b000000};
        vecs[1]  = '{32'h22, 1'b1, 4'b0000, 3'b000, {32'h00, 32'h11, 32'h22}, 3'b011, 6'b000000};
        vecs[2]  = '{32'h33, 1'b1, 4'b0000, 3'b000, {32'h11, 32'h22, 32'h33}, 3'b111, 6'b000000};
        vecs[3]  = '{32'h44, 1'b0, 4'b0000, 3'b000, {32'h22, 32'h33, 32'h44}, 3'b110, 6'b000000};
        vecs[4]  = '{32'h55, 1'b0, 4'b0000, 3'b000, {32'h33, 32'h44, 32'h55}, 3'b100, 6'b000000};
        vecs[5]  = '{32'h0C, 1'b1, 4'b0000, 3'b000, {32'h44, 32'h55, 32'h0C}, 3'b001, 6'b000000};
        vecs[6]  = '{32'h0B, 1'b1, 4'b0000, 3'b000, {32'h55, 32'h0C, 32'h0B}, 3'b011, 6'b000000};
        vecs[7]  = '{32'h0A, 1'b1, 4'b0000, 3'b000, {32'h0C, 32'h0B, 32'h0A}, 3'b111, 6'b000000};
        // Prefix stall: reg0 holds, reg1 bubbles, reg2 advances.
        vecs[8]  = '{32'hFF, 1'b1, 4'b0011, 3'b000, {32'h0B, 32'h00, 32'h0A}, 3'b101, 6'b000100};
        vecs[9]  = '{32'hEE, 1'b1, 4'b1111, 3'b000, {32'h0B, 32'h00, 32'h0A}, 3'b101, 6'b000100};
        vecs[10] = '{32'hEE, 1'b1, 4'b1111, 3'b000, {32'h0B, 32'h00, 32'h0A}, 3'b101, 6'b000100};
        vecs[11] = '{32'hEE, 1'b1, 4'b1111, 3'b000, {32'h0B, 32'h00, 32'h0A}, 3'b101, 6'b000100};
        vecs[12] = '{32'h0D, 1'b1, 4'b0000, 3'b000, {32'h00, 32'h0A, 32'h0D}, 3'b011, 6'b000100};
        // Flush beats a full stall.
        vecs[13] = '{32'h77, 1'b1, 4'b1111, 3'b010, {32'h00, 32'h00, 32'h0D}, 3'b001, 6'b001000};
        vecs[14] = '{32'h01, 1'b1, 4'b0000, 3'b001, {32'h00, 32'h0D, 32'h00}, 3'b010, 6'b001001};
        vecs[15] = '{32'h02, 1'b1, 4'b0000, 3'b000, {32'h0D, 32'h00, 32'h02}, 3'b101, 6'b001001};
        vecs[16] = '{32'h03, 1'b1, 4'b0000, 3'b001, {32'h00, 32'h02, 32'h00}, 3'b010, 6'b001010};
        vecs[17] = '{32'h04, 1'b1, 4'b0000, 3'b000, {32'h02, 32'h00, 32'h04}, 3'b101, 6'b001010};
        vecs[18] = '{32'h05, 1'b1, 4'b0000, 3'b001, {32'h00, 32'h04, 32'h00}, 3'b010, 6'b001011};
        vecs[19] = '{32'h06, 1'b1, 4'b0000, 3'b000, {32'h04, 32'h00, 32'h06}, 3'b101, 6'b001011};
        // Further valid bubbles at reg0 must leave its saturated counter at 3.
        vecs[20] = '{32'h07, 1'b1, 4'b0001, 3'b000, {32'h00, 32'h06, 32'h00}, 3'b010, 6'b001011};
        vecs[21] = '{32'h08, 1'b1, 4'b0000, 3'b000, {32'h06, 32'h00, 32'h08}, 3'b101, 6'b001011};
        vecs[22] = '{32'h09, 1'b1, 4'b0001, 3'b000, {32'h00, 32'h08, 32'h00}, 3'b010, 6'b001011};
        vecs[23] = '{32'h0F, 1'b1, 4'b0000, 3'b000, {32'h08, 32'h00, 32'h0F}, 3'b101, 6'b001011};
        // Consumer stalled with reg2 stalled: last register holds.
        vecs[24] = '{32'h10, 1'b1, 4'b1100, 3'b000, {32'h08, 32'h0F, 32'h10}, 3'b111, 6'b001011};
        vecs[25] = '{32'h11, 1'b0, 4'b1000, 3'b000, {32'h0F, 32'h10, 32'h11}, 3'b110, 6'b001011};

        rst = 1'b0; in_data = '0; in_valid = 1'b0; stall = '0; flush = '0;
        #2;
        check("reset_vld", 96'(stage_valid), 96'(0));
        check("reset_dat", 96'(stage_data), 96'(0));
        check_cnt("reset_cnt", 6'b0);
        #1 rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            in_data  = vecs[i].in_dat;
            in_valid = vecs[i].in_vld;
            stall    = vecs[i].stl;
            flush    = vecs[i].fls;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            begin
                vec_t e;
                e = exp_q.pop_front();
                check($sformatf("v%0d_dat", i), 96'(stage_data), e.exp_dat);
                check($sformatf("v%0d_vld", i), 96'(stage_valid), 96'(e.exp_vld));
                check($sformatf("v%0d_out", i), 96'({out_valid, out_data}),
                      96'({e.exp_vld[2], e.exp_dat[95:64]}));
                check_cnt($sformatf("v%0d_cnt", i), e.exp_cnt);
            end
        end

        // Asynchronous reset mid-cycle with valid data in flight.
        in_valid = 1'b1; in_data = 32'hAB; stall = '0; flush = '0;
        #2 rst = 1'b0;
        #1;
        check("arst_vld", 96'(stage_valid), 96'(0));
        check("arst_dat", 96'(stage_data), 96'(0));
        check_cnt("arst_cnt", 6'b0);
        @(posedge clk);
        #1;
        check("arst_hold_vld", 96'(stage_valid), 96'(0));
        #2 rst = 1'b1;
        in_valid = 1'b0; in_data = 32'h5A;
        @(posedge clk);
        #1;
        check("rel_vld", 96'(stage_valid), 96'(0));
        check("rel_dat", 96'(stage_data), {32'h0, 32'h0, 32'h5A});
        in_valid = 1'b1; in_data = 32'h5B;
        @(posedge clk);
        #1;
        check("rel2_vld", 96'(stage_valid), 96'(3'b001));
        check("rel2_dat", 96'(stage_data), {32'h0, 32'h5A, 32'h5B});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
